wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writeback-side receiver for the functional-unit result buses (ALU-misc, memory, multiplier *_wb_* outputs).
//  Buffers each unit's results in a small per-unit FIFO and round-robin arbitrates them onto the single ARF write port.
//  Pulses a scoreboard-clear for every completed instruction. Raises an issue stall when buffered results near capacity.
// PARAMETERS
//  DEPTH         4   entries per per-unit FIFO (power of 2, >=2)
//  STALL_THRESH  3   total buffered entries (all FIFOs) at/above which wb_iss_stall asserts
// PORTS
//  clock            in   1   rising-edge clock
//  reset            in   1   asynchronous, active-low
//  alu_wb_oper      in   1   ALU-misc result valid this cycle
//  alu_wb_regdest   in   5   ALU-misc destination register
//  alu_wb_writereg  in   1   ALU-misc ARF write enable (overflow already folded in)
//  alu_wb_wbvalue   in   32  ALU-misc result value
//  mem_wb_*         in   1/5/1/32  same four fields, memory unit
//  mul_wb_*         in   1/5/1/32  same four fields, multiplier unit
//  wb_rf_writereg   out  1   ARF write enable
//  wb_rf_regdest    out  5   ARF write address
//  wb_rf_wbvalue    out  32  ARF write data
//  wb_sb_clear      out  1   scoreboard pending-bit clear pulse
//  wb_sb_regdest    out  5   register whose pending bit is cleared
//  wb_iss_stall     out  1   issue stall request
//  wb_err_ovf       out  1   sticky: a result arrived at a full FIFO
// BEHAVIOUR
//  - Reset (async, reset==0): all outputs 0, FIFOs empty, RR pointer=0 (ALU), wb_err_ovf cleared. Mid-operation reset discards buffered results.
//  - Capture: on posedge, each unit with *_wb_oper=1 pushes {regdest,writereg,wbvalue} into its FIFO. Inputs with oper=0 are ignored whatever the other fields hold.
//  - Arbitration: among non-empty FIFO heads, grant the first at/after RR pointer, in order ALU(0),MEM(1),MUL(2). Exactly one grant per cycle max.
//    The pointer then moves to winner+1 mod 3. Pointer holds when no head is valid.
//  - Output register (updated every posedge from the granted head):
//    wb_sb_clear=1, wb_sb_regdest=regdest.
//    wb_rf_writereg=writereg & (regdest!=0); wb_rf_regdest=regdest; wb_rf_wbvalue=wbvalue.
//    No grant: wb_sb_clear=0, wb_rf_writereg=0, wb_rf_regdest=0, wb_rf_wbvalue=0.
//  - writereg=0 entries (e.g. overflow-suppressed) still consume a grant and still pulse wb_sb_clear.
//  - Latency: input edge -> visible on wb_rf_*: 2 cycles uncontended (FIFO, then output reg). +1 cycle per losing arbitration round.
//  - Ordering: FIFO order is preserved per unit. No cross-unit reordering guarantees; issue logic prevents WAW across units.
//  - Same-cycle push+pop on one FIFO is legal, including when full: the pop frees the slot first. Count unchanged.
//  - Push to a full FIFO with no simultaneous pop of that FIFO: the new entry is dropped and wb_err_ovf sets. It stays set until reset.
//  - wb_iss_stall: registered. Set when total occupancy after this edge >= STALL_THRESH, else cleared.
//  - Pointer wrap: FIFO read/write pointers are log2(DEPTH)+1 bits, wrapping naturally. Full = MSBs differ and LSBs equal.
// CONFIGURATION
//  WB_BYPASS_EN defined: an input arriving at an EMPTY FIFO may win arbitration in the same cycle.
//    It competes at its RR slot and goes straight to the output register without being pushed. Uncontended latency = 1 cycle.
//    If it loses arbitration, it is pushed normally.
//  WB_BYPASS_EN undefined: every result goes through its FIFO. Uncontended latency = 2 cycles.
// STRUCTURE
//  - Shared include wb_defs.vh holds:
//    localparams FU_ALU=0, FU_MEM=1, FU_MUL=2, NUM_FU=3.
//    WB_ENTRY_W=38 and the field offsets for {regdest[37:33], writereg[32], wbvalue[31:0]}.
//  - Sub-module wb_fifo: DEPTH x WB_ENTRY_W synchronous FIFO.
//    Ports: push, pop, din, dout, empty, full, count. Async active-low reset.
//    Instantiated three times. Arbiter, RR pointer, output regs and stall/err logic live in wb_arbiter.
// TESTING
//  1 Reset: hold reset=0 with inputs toggling -> all outputs 0. After release, no write until an oper pulse arrives.
//  2 Single ALU result: alu oper=1, rd=5, wr=1, val=0xDEADBEEF.
//    -> 2 cycles later (1 with WB_BYPASS_EN): rf_writereg=1, rd=5, val=0xDEADBEEF, sb_clear=1 rd=5, for one cycle.
//  3 Collision: ALU rd=1, MEM rd=2, MUL rd=3 in the same cycle, pointer=0.
//    -> writes on three consecutive cycles: r1, r2, r3. Pointer ends at 0.
//  4 Suppressed/r0: alu rd=7 wr=0, then alu rd=0 wr=1 val=0x1.
//    -> rf_writereg=0 on both. sb_clear=1 with rd=7, then rd=0.
//  5 Fill: MEM rd=9..(9+DEPTH) on consecutive cycles while ALU+MUL push every cycle too (DEPTH=4).
//    -> wb_iss_stall rises once occupancy >=3. wb_err_ovf sets on the first dropped push. All accepted entries drain in FIFO order.
//  6 Reset mid-drain: assert reset with 5 entries buffered.
//    -> outputs 0 immediately. After release, no stale writes appear.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback definitions: functional-unit indices, result-entry layout and the
// round-robin index helper used by wb_arbiter.
package wb_arbiter_pkg;

    localparam int unsigned FU_ALU = 0;
    localparam int unsigned FU_MEM = 1;
    localparam int unsigned FU_MUL = 2;
    localparam int unsigned NUM_FU = 3;

    // Entry layout: {regdest[37:33], writereg[32], wbvalue[31:0]}
    localparam int unsigned WB_ENTRY_W = 38;
    localparam int unsigned WB_RD_MSB  = 37;
    localparam int unsigned WB_RD_LSB  = 33;
    localparam int unsigned WB_WR_BIT  = 32;
    localparam int unsigned WB_VAL_MSB = 31;

    function automatic logic [1:0] fu_add(logic [1:0] base, int unsigned off);
        return 2'((32'(base) + off) % NUM_FU);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH x WIDTH synchronous FIFO with wrap-bit pointers; a push to a full FIFO is
// accepted only when a pop of the same FIFO happens in that cycle.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 38
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_pop  = pop && !empty;
    // When full, the write lands in the slot the simultaneous pop is vacating.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs, round-robin onto the ARF write port,
// scoreboard clear, issue stall and sticky overflow. WB_BYPASS_EN enables empty-FIFO bypass.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_THRESH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_wb_oper,
    input  logic [4:0]  alu_wb_regdest,
    input  logic        alu_wb_writereg,
    input  logic [31:0] alu_wb_wbvalue,
    input  logic        mem_wb_oper,
    input  logic [4:0]  mem_wb_regdest,
    input  logic        mem_wb_writereg,
    input  logic [31:0] mem_wb_wbvalue,
    input  logic        mul_wb_oper,
    input  logic [4:0]  mul_wb_regdest,
    input  logic        mul_wb_writereg,
    input  logic [31:0] mul_wb_wbvalue,
    output logic        wb_rf_writereg,
    output logic [4:0]  wb_rf_regdest,
    output logic [31:0] wb_rf_wbvalue,
    output logic        wb_sb_clear,
    output logic [4:0]  wb_sb_regdest,
    output logic        wb_iss_stall,
    output logic        wb_err_ovf
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [NUM_FU-1:0]     w_oper;
    logic [WB_ENTRY_W-1:0] w_in_entry [NUM_FU];
    logic [WB_ENTRY_W-1:0] w_head     [NUM_FU];
    logic [WB_ENTRY_W-1:0] w_cand     [NUM_FU];
    logic [CW-1:0]         w_count    [NUM_FU];
    logic [NUM_FU-1:0]     w_empty;
    logic [NUM_FU-1:0]     w_full;
    logic [NUM_FU-1:0]     w_vld;
    logic [NUM_FU-1:0]     w_sel;
    logic [NUM_FU-1:0]     w_pop;
    logic [NUM_FU-1:0]     w_byp;
    logic [NUM_FU-1:0]     w_push;
    logic [NUM_FU-1:0]     w_acc;
    logic [NUM_FU-1:0]     w_drop;
    logic                  w_gnt;
    logic [1:0]            w_gnt_idx;
    logic [WB_ENTRY_W-1:0] w_gnt_entry;
    logic [4:0]            w_gnt_rd;
    logic [31:0]           w_occ_next;

    logic [1:0]  r_ptr;
    logic        r_rf_writereg;
    logic [4:0]  r_rf_regdest;
    logic [31:0] r_rf_wbvalue;
    logic        r_sb_clear;
    logic [4:0]  r_sb_regdest;
    logic        r_iss_stall;
    logic        r_err_ovf;

    assign w_oper = {mul_wb_oper, mem_wb_oper, alu_wb_oper};
    assign w_in_entry[FU_ALU] = {alu_wb_regdest, alu_wb_writereg, alu_wb_wbvalue};
    assign w_in_entry[FU_MEM] = {mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue};
    assign w_in_entry[FU_MUL] = {mul_wb_regdest, mul_wb_writereg, mul_wb_wbvalue};

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
        wb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (WB_ENTRY_W)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .din   (w_in_entry[g]),
            .dout  (w_head[g]),
            .empty (w_empty[g]),
            .full  (w_full[g]),
            .count (w_count[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
`ifdef WB_BYPASS_EN
            w_vld[i]  = !w_empty[i] || w_oper[i];
            w_cand[i] = w_empty[i] ? w_in_entry[i] : w_head[i];
`else
            w_vld[i]  = !w_empty[i];
            w_cand[i] = w_head[i];
`endif
        end
    end

    // First valid candidate at or after the round-robin pointer.
    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (!w_gnt && w_vld[fu_add(r_ptr, k)]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = fu_add(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_occ_next = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_sel[i]  = w_gnt && (w_gnt_idx == 2'(i));
            w_pop[i]  = w_sel[i] && !w_empty[i];
`ifdef WB_BYPASS_EN
            w_byp[i]  = w_sel[i] && w_empty[i];
`else
            w_byp[i]  = 1'b0;
`endif
            w_push[i] = w_oper[i] && !w_byp[i];
            w_acc[i]  = w_push[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = w_push[i] && w_full[i] && !w_pop[i];
            w_occ_next = w_occ_next + 32'(w_count[i]) + {31'b0, w_acc[i]} - {31'b0, w_pop[i]};
        end
    end

    assign w_gnt_entry = w_cand[w_gnt_idx];
    assign w_gnt_rd    = w_gnt_entry[WB_RD_MSB:WB_RD_LSB];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr         <= 2'(FU_ALU);
            r_rf_writereg <= 1'b0;
            r_rf_regdest  <= '0;
            r_rf_wbvalue  <= '0;
            r_sb_clear    <= 1'b0;
            r_sb_regdest  <= '0;
            r_iss_stall   <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_ptr         <= fu_add(w_gnt_idx, 1);
                r_rf_writereg <= w_gnt_entry[WB_WR_BIT] && (w_gnt_rd != 5'd0);
                r_rf_regdest  <= w_gnt_rd;
                r_rf_wbvalue  <= w_gnt_entry[WB_VAL_MSB:0];
                r_sb_clear    <= 1'b1;
                r_sb_regdest  <= w_gnt_rd;
            end else begin
                r_rf_writereg <= 1'b0;
                r_rf_regdest  <= '0;
                r_rf_wbvalue  <= '0;
                r_sb_clear    <= 1'b0;
                r_sb_regdest  <= '0;
            end
            r_iss_stall <= (w_occ_next >= STALL_THRESH);
            if (|w_drop) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    assign wb_rf_writereg = r_rf_writereg;
    assign wb_rf_regdest  = r_rf_regdest;
    assign wb_rf_wbvalue  = r_rf_wbvalue;
    assign wb_sb_clear    = r_sb_clear;
    assign wb_sb_regdest  = r_sb_regdest;
    assign wb_iss_stall   = r_iss_stall;
    assign wb_err_ovf     = r_err_ovf;

endmodule
